// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - store-type constants, FSM state type and byte-lane helpers for dcache_wb
package cache_pkg;

  localparam logic [1:0] ST_SW = 2'b00;
  localparam logic [1:0] ST_SH = 2'b01;
  localparam logic [1:0] ST_SB = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WB     = 2'd1,
    S_REFILL = 2'd2
  } dcache_state_e;

  function automatic logic [3:0] be_from_store(input logic [1:0] st, input logic [1:0] a);
    case (st)
      ST_SH:   return a[1] ? 4'b1100 : 4'b0011;
      ST_SB:   return 4'b0001 << a;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate the stored halfword/byte onto every lane; the byte enables pick the live ones.
  function automatic logic [31:0] store_lanes(input logic [1:0] st, input logic [31:0] d);
    case (st)
      ST_SH:   return {2{d[15:0]}};
      ST_SB:   return {4{d[7:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/dcache_wb_if.sv
// rtl/dcache_wb_if.sv - CPU-side and burst-memory-side interfaces of dcache_wb
interface dcache_cpu_if;
  logic        MEM_Req_i;
  logic        MEM_DMWr_i;
  logic [31:0] MEM_Addr_i;
  logic [31:0] MEM_WData_i;
  logic [1:0]  MEM_StoreType_i;
  logic [31:0] MEM_RData_o;
  logic        MEM_Stall_o;

  modport master (
    output MEM_Req_i, MEM_DMWr_i, MEM_Addr_i, MEM_WData_i, MEM_StoreType_i,
    input  MEM_RData_o, MEM_Stall_o
  );
  modport slave (
    input  MEM_Req_i, MEM_DMWr_i, MEM_Addr_i, MEM_WData_i, MEM_StoreType_i,
    output MEM_RData_o, MEM_Stall_o
  );
endinterface

interface dcache_bus_if;
  logic        Bus_RdReq_o;
  logic [31:0] Bus_RdAddr_o;
  logic        Bus_RdValid_i;
  logic [31:0] Bus_RdData_i;
  logic        Bus_WrReq_o;
  logic [31:0] Bus_WrAddr_o;
  logic [31:0] Bus_WrData_o;
  logic        Bus_WrReady_i;

  modport master (
    output Bus_RdReq_o, Bus_RdAddr_o, Bus_WrReq_o, Bus_WrAddr_o, Bus_WrData_o,
    input  Bus_RdValid_i, Bus_RdData_i, Bus_WrReady_i
  );
  modport slave (
    input  Bus_RdReq_o, Bus_RdAddr_o, Bus_WrReq_o, Bus_WrAddr_o, Bus_WrData_o,
    output Bus_RdValid_i, Bus_RdData_i, Bus_WrReady_i
  );
endinterface

// File: rtl/dcache_line_ram.sv
// rtl/dcache_line_ram.sv - cache data array, async read, per-byte synchronous write
module dcache_line_ram #(
  parameter int INDEX_W = 6,
  parameter int OFF_W   = 2
) (
  input  logic               i_clk,
  input  logic [INDEX_W-1:0] i_idx,
  input  logic [OFF_W-1:0]   i_rd_word,
  output logic [31:0]        o_rd_data,
  input  logic [OFF_W-1:0]   i_wr_word,
  input  logic [3:0]         i_wr_be,
  input  logic [31:0]        i_wr_data
);
  localparam int DEPTH = 1 << (INDEX_W + OFF_W);

  logic [31:0] r_mem [DEPTH];

  assign o_rd_data = r_mem[{i_idx, i_rd_word}];

  always_ff @(posedge i_clk) begin
    for (int b = 0; b < 4; b++) begin
      if (i_wr_be[b]) begin
        r_mem[{i_idx, i_wr_word}][8*b +: 8] <= i_wr_data[8*b +: 8];
      end
    end
  end
endmodule

// File: rtl/dcache_wb.sv
// rtl/dcache_wb.sv - direct-mapped write-back write-allocate data cache with burst refill/writeback
// Optional hit/miss/writeback counters are built when DCACHE_PERF_CNT_EN is defined.
module dcache_wb
  import cache_pkg::*;
#(
  parameter int INDEX_W    = 6,
  parameter int LINE_WORDS = 4
) (
  input  logic         clk,
  input  logic         rst,
  dcache_cpu_if.slave  cpu,
  dcache_bus_if.master bus
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0]  Perf_Hit_o,
  output logic [31:0]  Perf_Miss_o,
  output logic [31:0]  Perf_Wb_o
`endif
);
  localparam int LINES = 1 << INDEX_W;
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int TAG_W = 32 - INDEX_W - OFF_W - 2;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

  dcache_state_e    r_state;
  dcache_state_e    w_next;
  logic [OFF_W-1:0] r_cnt;
  logic [LINES-1:0] r_valid;
  logic [LINES-1:0] r_dirty;
  logic [TAG_W-1:0] r_tag [LINES];

  logic [TAG_W-1:0]   w_tag;
  logic [INDEX_W-1:0] w_idx;
  logic [OFF_W-1:0]   w_off;
  logic               w_hit;
  logic               w_miss;
  logic               w_store_hit;
  logic               w_refill_beat;
  logic               w_refill_done;
  logic               w_wb_beat;
  logic               w_wb_done;
  logic [OFF_W-1:0]   w_ram_word;
  logic [3:0]         w_ram_be;
  logic [31:0]        w_ram_wdata;
  logic [31:0]        w_ram_rdata;

  assign w_tag = cpu.MEM_Addr_i[31 -: TAG_W];
  assign w_idx = cpu.MEM_Addr_i[OFF_W+2 +: INDEX_W];
  assign w_off = cpu.MEM_Addr_i[2 +: OFF_W];

  assign w_hit         = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_miss        = (r_state == S_IDLE) && cpu.MEM_Req_i && !w_hit;
  assign w_store_hit   = (r_state == S_IDLE) && cpu.MEM_Req_i && cpu.MEM_DMWr_i && w_hit;
  assign w_refill_beat = (r_state == S_REFILL) && bus.Bus_RdValid_i;
  assign w_refill_done = w_refill_beat && (r_cnt == LAST_BEAT);
  assign w_wb_beat     = (r_state == S_WB) && bus.Bus_WrReady_i;
  assign w_wb_done     = w_wb_beat && (r_cnt == LAST_BEAT);

  // The CPU holds its address while stalled, so w_idx also names the victim/refill line.
  assign w_ram_word  = (r_state == S_IDLE) ? w_off : r_cnt;
  assign w_ram_be    = w_store_hit   ? be_from_store(cpu.MEM_StoreType_i, cpu.MEM_Addr_i[1:0]) :
                       w_refill_beat ? 4'b1111 : 4'b0000;
  assign w_ram_wdata = w_refill_beat ? bus.Bus_RdData_i
                                     : store_lanes(cpu.MEM_StoreType_i, cpu.MEM_WData_i);

  dcache_line_ram #(
    .INDEX_W (INDEX_W),
    .OFF_W   (OFF_W)
  ) u_line_ram (
    .i_clk     (clk),
    .i_idx     (w_idx),
    .i_rd_word (w_ram_word),
    .o_rd_data (w_ram_rdata),
    .i_wr_word (w_ram_word),
    .i_wr_be   (w_ram_be),
    .i_wr_data (w_ram_wdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_miss) w_next = (r_valid[w_idx] && r_dirty[w_idx]) ? S_WB : S_REFILL;
      S_WB:     if (w_wb_done) w_next = S_REFILL;
      S_REFILL: if (w_refill_done) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    cpu.MEM_RData_o  = w_ram_rdata;
    cpu.MEM_Stall_o  = (r_state != S_IDLE) || w_miss;
    bus.Bus_RdReq_o  = (r_state == S_REFILL);
    bus.Bus_RdAddr_o = {cpu.MEM_Addr_i[31:OFF_W+2], {(OFF_W+2){1'b0}}};
    bus.Bus_WrReq_o  = (r_state == S_WB);
    bus.Bus_WrAddr_o = {r_tag[w_idx], w_idx, {(OFF_W+2){1'b0}}};
    bus.Bus_WrData_o = w_ram_rdata;
  end

  // Beat counter wraps to zero after the last beat, ready for the next burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            r_cnt <= '0;
    else if (w_wb_beat || w_refill_beat) r_cnt <= r_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (w_refill_done) begin
      r_valid[w_idx] <= 1'b1;
      r_dirty[w_idx] <= 1'b0;
    end else if (w_store_hit) begin
      r_dirty[w_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_refill_done) r_tag[w_idx] <= w_tag;
  end

`ifdef DCACHE_PERF_CNT_EN
  logic        r_replay;
  logic [31:0] r_perf_hit;
  logic [31:0] r_perf_miss;
  logic [31:0] r_perf_wb;

  // The hit that replays a just-refilled access is already counted as a miss.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_replay    <= 1'b0;
      r_perf_hit  <= '0;
      r_perf_miss <= '0;
      r_perf_wb   <= '0;
    end else begin
      r_replay <= w_refill_done;
      if ((r_state == S_IDLE) && cpu.MEM_Req_i && w_hit && !r_replay) r_perf_hit <= r_perf_hit + 1'b1;
      if (w_miss)                        r_perf_miss <= r_perf_miss + 1'b1;
      if (w_miss && (w_next == S_WB))    r_perf_wb   <= r_perf_wb + 1'b1;
    end
  end

  assign Perf_Hit_o  = r_perf_hit;
  assign Perf_Miss_o = r_perf_miss;
  assign Perf_Wb_o   = r_perf_wb;
`endif

endmodule

// File: tb/tb_dcache_wb.sv
// tb/tb_dcache_wb.sv - self-checking bench for dcache_wb against a flat-memory reference model
module tb_dcache_wb;
  localparam int INDEX_W    = 6;
  localparam int LINE_WORDS = 4;
  localparam int LINES      = 64;
  localparam int LINE_BYTES = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dcache_cpu_if cpu ();
  dcache_bus_if bus ();

`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] perf_hit, perf_miss, perf_wb;
`endif

  dcache_wb #(
    .INDEX_W    (INDEX_W),
    .LINE_WORDS (LINE_WORDS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .cpu (cpu),
    .bus (bus)
`ifdef DCACHE_PERF_CNT_EN
    ,
    .Perf_Hit_o  (perf_hit),
    .Perf_Miss_o (perf_miss),
    .Perf_Wb_o   (perf_wb)
`endif
  );

  int checks = 0;
  int errors = 0;

  // gmem: what a program would see from a flat RAM; bmem: the backing memory behind the bus.
  logic [31:0] gmem [int];
  logic [31:0] bmem [int];

  bit        mvalid [LINES];
  bit        mdirty [LINES];
  int        mtag   [LINES];
  int        exp_hits, exp_misses, exp_wbs;

  bit          exp_hit, exp_wb;
  logic [31:0] victim;

  bit          rand_mode = 1'b0;
  bit          wr_manual = 1'b0;
  int          rbeat = 0;
  int          wbeat = 0;
  logic [31:0] rd_log [$];
  logic [31:0] wb_addr_log [$];
  logic [31:0] wb_data_log [$];

  function automatic logic [31:0] dflt(input int wa);
    return (wa * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction
  function automatic logic [31:0] gget(input int wa);
    return gmem.exists(wa) ? gmem[wa] : dflt(wa);
  endfunction
  function automatic logic [31:0] bget(input int wa);
    return bmem.exists(wa) ? bmem[wa] : dflt(wa);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [1:0] st,
                                        input logic [1:0] a, input logic [31:0] d);
    logic [31:0] r;
    r = old;
    case (st)
      2'b01:   if (a[1]) r[31:16] = d[15:0]; else r[15:0] = d[15:0];
      2'b10:   r[a*8 +: 8] = d[7:0];
      default: r = d;
    endcase
    return r;
  endfunction

  // Memory side of the bus: logs accepted beats at negedge, drives next-cycle inputs after posedge.
  initial begin
    bus.Bus_RdValid_i = 1'b0;
    bus.Bus_RdData_i  = '0;
    bus.Bus_WrReady_i = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.Bus_RdReq_o && bus.Bus_RdValid_i) begin
        if (rbeat == 0) rd_log.push_back(bus.Bus_RdAddr_o);
        rbeat++;
      end else if (!bus.Bus_RdReq_o) begin
        rbeat = 0;
      end
      if (bus.Bus_WrReq_o && bus.Bus_WrReady_i) begin
        wb_addr_log.push_back(bus.Bus_WrAddr_o);
        wb_data_log.push_back(bus.Bus_WrData_o);
        bmem[int'(bus.Bus_WrAddr_o >> 2) + wbeat] = bus.Bus_WrData_o;
        wbeat++;
      end else if (!bus.Bus_WrReq_o) begin
        wbeat = 0;
      end
      @(posedge clk);
      #1;
      bus.Bus_RdValid_i = bus.Bus_RdReq_o && (!rand_mode || ($urandom_range(0, 3) != 0));
      bus.Bus_RdData_i  = bget(int'(bus.Bus_RdAddr_o >> 2) + rbeat);
      if (!wr_manual) bus.Bus_WrReady_i = !rand_mode || ($urandom_range(0, 2) != 0);
    end
  end

  task automatic begin_model(input logic [31:0] addr);
    int idx, tag;
    idx = (addr / LINE_BYTES) % LINES;
    tag = addr / (LINE_BYTES * LINES);
    exp_hit = mvalid[idx] && (mtag[idx] == tag);
    exp_wb  = !exp_hit && mvalid[idx] && mdirty[idx];
    victim  = mtag[idx] * LINE_BYTES * LINES + idx * LINE_BYTES;
    rd_log.delete();
    wb_addr_log.delete();
    wb_data_log.delete();
  endtask

  task automatic end_model(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                           input logic [1:0] st, input logic [31:0] rdata, input int stalls,
                           input int extra);
    int idx, tag, wa;
    logic [31:0] line;
    idx  = (addr / LINE_BYTES) % LINES;
    tag  = addr / (LINE_BYTES * LINES);
    wa   = int'(addr >> 2);
    line = addr & ~32'(LINE_BYTES - 1);
    checks++;
    if ((stalls == 0) !== exp_hit) begin
      errors++;
      $display("FAIL hit_status addr=%h stalls=%0d expected_hit=%0d", addr, stalls, exp_hit);
    end
    checks++;
    if (rd_log.size() !== (exp_hit ? 0 : 1) || (!exp_hit && rd_log.size() == 1 && rd_log[0] !== line)) begin
      errors++;
      $display("FAIL refill addr=%h refills=%0d first=%h expected_line=%h", addr, rd_log.size(),
               (rd_log.size() > 0) ? rd_log[0] : 32'h0, line);
    end
    checks++;
    if (wb_data_log.size() !== (exp_wb ? LINE_WORDS : 0)) begin
      errors++;
      $display("FAIL wb_beats addr=%h got=%0d expected=%0d", addr, wb_data_log.size(), exp_wb ? LINE_WORDS : 0);
    end else begin
      for (int i = 0; i < wb_data_log.size(); i++) begin
        checks++;
        if (wb_addr_log[i] !== victim || wb_data_log[i] !== gget(int'(victim >> 2) + i)) begin
          errors++;
          $display("FAIL wb_beat%0d got addr=%h data=%h expected addr=%h data=%h", i, wb_addr_log[i],
                   wb_data_log[i], victim, gget(int'(victim >> 2) + i));
        end
      end
    end
    if (!rand_mode && !exp_hit) begin
      checks++;
      if (stalls !== (exp_wb ? 2 * LINE_WORDS : LINE_WORDS) + 1 + extra) begin
        errors++;
        $display("FAIL miss_latency addr=%h got=%0d expected=%0d", addr, stalls,
                 (exp_wb ? 2 * LINE_WORDS : LINE_WORDS) + 1 + extra);
      end
    end
    if (!wr) begin
      checks++;
      if (rdata !== gget(wa)) begin
        errors++;
        $display("FAIL load_data addr=%h got=%h expected=%h", addr, rdata, gget(wa));
      end
    end else begin
      gmem[wa] = merge(gget(wa), st, addr[1:0], data);
    end
    if (exp_hit) exp_hits++;
    else exp_misses++;
    if (exp_wb) exp_wbs++;
    if (!exp_hit) begin
      mvalid[idx] = 1'b1;
      mtag[idx]   = tag;
      mdirty[idx] = 1'b0;
    end
    if (wr) mdirty[idx] = 1'b1;
  endtask

  // Called just after a posedge; returns with Req dropped just after a later posedge.
  task automatic access(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [1:0] st, output logic [31:0] rdata, output int stalls);
    bit done;
    begin_model(addr);
    cpu.MEM_Req_i = 1'b1;
    cpu.MEM_DMWr_i = wr;
    cpu.MEM_Addr_i = addr;
    cpu.MEM_WData_i = data;
    cpu.MEM_StoreType_i = st;
    stalls = 0;
    done = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (!cpu.MEM_Stall_o) begin
        done = 1'b1;
        break;
      end
      stalls++;
    end
    rdata = cpu.MEM_RData_o;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL access_timeout addr=%h stalls=%0d expected=<300", addr, stalls);
    end
    @(posedge clk);
    #1;
    cpu.MEM_Req_i = 1'b0;
    end_model(wr, addr, data, st, rdata, stalls, 0);
  endtask

  task automatic reset_model();
    for (int i = 0; i < LINES; i++) begin
      mvalid[i] = 1'b0;
      mdirty[i] = 1'b0;
      mtag[i]   = 0;
    end
    gmem = bmem;
    exp_hits = 0;
    exp_misses = 0;
    exp_wbs = 0;
  endtask

  task automatic test_reset();
    cpu.MEM_Req_i = 1'b0;
    cpu.MEM_DMWr_i = 1'b0;
    cpu.MEM_Addr_i = '0;
    cpu.MEM_WData_i = '0;
    cpu.MEM_StoreType_i = 2'b00;
    rst = 1'b1;
    reset_model();
    repeat (3) @(negedge clk);
    checks++;
    if ({cpu.MEM_Stall_o, bus.Bus_RdReq_o, bus.Bus_WrReq_o} !== 3'b000) begin
      errors++;
      $display("FAIL reset_outputs stall/rdreq/wrreq=%b expected=000",
               {cpu.MEM_Stall_o, bus.Bus_RdReq_o, bus.Bus_WrReq_o});
    end
`ifdef DCACHE_PERF_CNT_EN
    checks++;
    if ({perf_hit, perf_miss, perf_wb} !== 96'h0) begin
      errors++;
      $display("FAIL reset_perf got=%h/%h/%h expected=0", perf_hit, perf_miss, perf_wb);
    end
`endif
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_refill_and_store();
    logic [31:0] rd;
    int st;
    rand_mode = 1'b0;
    bmem[32'h40] = 32'h11; bmem[32'h41] = 32'h22; bmem[32'h42] = 32'h33; bmem[32'h43] = 32'h44;
    gmem[32'h40] = 32'h11; gmem[32'h41] = 32'h22; gmem[32'h42] = 32'h33; gmem[32'h43] = 32'h44;
    access(1'b0, 32'h100, 32'h0, 2'b00, rd, st);
    checks++;
    if (rd !== 32'h11) begin
      errors++;
      $display("FAIL first_refill_data got=%h expected=00000011", rd);
    end
    access(1'b1, 32'h103, 32'hAB, 2'b10, rd, st);
    access(1'b0, 32'h100, 32'h0, 2'b00, rd, st);
    checks++;
    if (rd !== 32'hAB000011 || st !== 0) begin
      errors++;
      $display("FAIL sb_merge got=%h stalls=%0d expected=ab000011 stalls=0", rd, st);
    end
    access(1'b0, 32'h100 + LINES * LINE_BYTES, 32'h0, 2'b00, rd, st);
    checks++;
    if (wb_data_log.size() < 1 || wb_data_log[0] !== 32'hAB000011 || wb_addr_log[0] !== 32'h100) begin
      errors++;
      $display("FAIL dirty_victim first wb beat got=%h @%h expected=ab000011 @00000100",
               (wb_data_log.size() > 0) ? wb_data_log[0] : 32'h0,
               (wb_addr_log.size() > 0) ? wb_addr_log[0] : 32'h0);
    end
  endtask

  task automatic test_halfword();
    logic [31:0] rd;
    int st;
    bmem[32'h82] = 32'h0;
    gmem[32'h82] = 32'h0;
    access(1'b0, 32'h208, 32'h0, 2'b00, rd, st);
    access(1'b1, 32'h20A, 32'h1234BEEF, 2'b01, rd, st);
    access(1'b0, 32'h208, 32'h0, 2'b00, rd, st);
    checks++;
    if (rd !== 32'hBEEF0000) begin
      errors++;
      $display("FAIL sh_upper got=%h expected=beef0000", rd);
    end
    access(1'b1, 32'h209, 32'hFFFF1234, 2'b01, rd, st);
    access(1'b0, 32'h208, 32'h0, 2'b00, rd, st);
    checks++;
    if (rd !== 32'hBEEF1234) begin
      errors++;
      $display("FAIL sh_lower got=%h expected=beef1234", rd);
    end
  endtask

  task automatic test_wb_backpressure();
    logic [31:0] rd, d0, a0;
    logic [31:0] addr;
    int st, b0;
    bit done, held;
    access(1'b1, 32'h704, 32'hCAFEF00D, 2'b00, rd, st);
    addr = 32'h700 + LINES * LINE_BYTES;
    wr_manual = 1'b1;
    bus.Bus_WrReady_i = 1'b1;
    begin_model(addr);
    cpu.MEM_Req_i = 1'b1;
    cpu.MEM_DMWr_i = 1'b0;
    cpu.MEM_Addr_i = addr;
    st = 0;
    done = 1'b0;
    held = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      #2;
      if (!cpu.MEM_Stall_o) begin
        done = 1'b1;
        break;
      end
      st++;
      if (!held && wbeat == 2) begin
        held = 1'b1;
        @(posedge clk);
        #1;
        bus.Bus_WrReady_i = 1'b0;
        @(negedge clk);
        #2;
        st++;
        d0 = bus.Bus_WrData_o;
        a0 = bus.Bus_WrAddr_o;
        b0 = wbeat;
        checks++;
        if (d0 !== gget(32'h1C2) || a0 !== 32'h700 || b0 !== 2) begin
          errors++;
          $display("FAIL wb_hold_start data=%h addr=%h beats=%0d expected %h 00000700 2", d0, a0, b0, gget(32'h1C2));
        end
        for (int k = 1; k < 5; k++) begin
          @(negedge clk);
          #2;
          st++;
          checks++;
          if (bus.Bus_WrData_o !== d0 || bus.Bus_WrAddr_o !== a0 || wbeat !== b0 || cpu.MEM_Stall_o !== 1'b1) begin
            errors++;
            $display("FAIL wb_hold cycle%0d data=%h addr=%h beats=%0d stall=%b expected %h %h %0d 1",
                     k, bus.Bus_WrData_o, bus.Bus_WrAddr_o, wbeat, cpu.MEM_Stall_o, d0, a0, b0);
          end
        end
        @(posedge clk);
        #1;
        bus.Bus_WrReady_i = 1'b1;
      end
    end
    rd = cpu.MEM_RData_o;
    checks++;
    if (!done || !held) begin
      errors++;
      $display("FAIL wb_hold_reached done=%0d held=%0d expected 1 1", done, held);
    end
    @(posedge clk);
    #1;
    cpu.MEM_Req_i = 1'b0;
    wr_manual = 1'b0;
    end_model(1'b0, addr, 32'h0, 2'b00, rd, st, 5);
  endtask

  task automatic test_reset_mid_refill();
    logic [31:0] rd;
    int st;
    bit reached;
    rand_mode = 1'b0;
    begin_model(32'h3040);
    cpu.MEM_Req_i = 1'b1;
    cpu.MEM_DMWr_i = 1'b0;
    cpu.MEM_Addr_i = 32'h3040;
    reached = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      #2;
      if (rbeat == 2) begin
        reached = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    cpu.MEM_Req_i = 1'b0;
    #1;
    checks++;
    if (!reached || {cpu.MEM_Stall_o, bus.Bus_RdReq_o, bus.Bus_WrReq_o} !== 3'b000) begin
      errors++;
      $display("FAIL async_reset reached=%0d stall/rdreq/wrreq=%b expected 1 000", reached,
               {cpu.MEM_Stall_o, bus.Bus_RdReq_o, bus.Bus_WrReq_o});
    end
    reset_model();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    access(1'b0, 32'h3040, 32'h0, 2'b00, rd, st);
    checks++;
    if (st == 0) begin
      errors++;
      $display("FAIL post_reset_miss stalls=%0d expected>0", st);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, addr, data;
    logic [1:0] stype;
    int st;
    bit wr;
    rand_mode = 1'b1;
    for (int n = 0; n < 300; n++) begin
      addr  = 32'h10000 + $urandom_range(0, 3) * LINES * LINE_BYTES + $urandom_range(0, 7) * LINE_BYTES
              + $urandom_range(0, 3) * 4 + $urandom_range(0, 3);
      wr    = $urandom_range(0, 1) == 1;
      data  = $urandom;
      stype = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        checks++;
        if (cpu.MEM_Stall_o !== 1'b0) begin
          errors++;
          $display("FAIL idle_stall got=%b expected=0", cpu.MEM_Stall_o);
        end
        @(posedge clk);
        #1;
      end
      access(wr, addr, data, stype, rd, st);
    end
`ifdef DCACHE_PERF_CNT_EN
    checks++;
    if (perf_hit !== 32'(exp_hits) || perf_miss !== 32'(exp_misses) || perf_wb !== 32'(exp_wbs)) begin
      errors++;
      $display("FAIL perf got=%0d/%0d/%0d expected=%0d/%0d/%0d", perf_hit, perf_miss, perf_wb,
               exp_hits, exp_misses, exp_wbs);
    end
`endif
    rand_mode = 1'b0;
  endtask

  initial begin
    test_reset();
    test_refill_and_store();
    test_halfword();
    test_wb_backpressure();
    test_reset_mid_refill();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
